pid_terms: RTL and testbench



---
 rtl/pid_terms.sv | 112 +++++++++++
 tb/tb_pid_terms.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pid_terms.sv
// Produces the registered P, I and D terms of the PID controller from the saturated error.
// Stage 1 registers the error, the saturated derivative difference and the guarded integrator; stage 2 forms the products.
module pid_terms #(
  parameter logic signed [5:0] P_COEFF = 6'sh08,
  parameter logic signed [5:0] D_COEFF = 6'sh07,
  parameter int unsigned       D_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [9:0]  err_sat,
  input  logic               err_vld,
  input  logic               moving,
  output logic signed [15:0] P_term,
  output logic signed [11:0] I_term,
  output logic signed [12:0] D_term,
  output logic               terms_vld
);

  localparam int unsigned EW = 10;  // error width
  localparam int unsigned DW = 11;  // raw difference width
  localparam int unsigned SW = 7;   // saturated difference width
  localparam int unsigned IW = 18;  // integrator width
  localparam int unsigned PW = 16;  // P term width
  localparam int unsigned TW = 13;  // D term width

  localparam logic signed [SW-1:0] SAT_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {1'b1, {(SW-1){1'b0}}};

  logic signed [EW-1:0] queue [D_DEPTH];
  logic signed [EW-1:0] err_q;
  logic signed [SW-1:0] diff_sat;
  logic                 s1_vld;
  logic signed [IW-1:0] integ;

  logic signed [DW-1:0] d_diff_c;
  logic signed [SW-1:0] diff_sat_c;
  logic signed [IW-1:0] sum_c;
  logic                 ovf_c;
  logic signed [IW-1:0] integ_nxt_c;
  logic signed [PW-1:0] p_prod_c;
  logic signed [TW-1:0] d_prod_c;

  // Derivative difference against the oldest tracked sample, clamped to 7 bits.
  always_comb begin
    d_diff_c   = DW'(err_sat) - DW'(queue[D_DEPTH-1]);
    diff_sat_c = d_diff_c[SW-1:0];
    if (d_diff_c > DW'(SAT_MAX)) begin
      diff_sat_c = SAT_MAX;
    end else if (d_diff_c < DW'(SAT_MIN)) begin
      diff_sat_c = SAT_MIN;
    end
  end

  // Integrator: clear wins, otherwise accumulate unless the add would overflow.
  always_comb begin
    sum_c       = integ + IW'(err_sat);
    ovf_c       = (integ[IW-1] == err_sat[EW-1]) && (sum_c[IW-1] != integ[IW-1]);
    integ_nxt_c = integ;
    if (!moving) begin
      integ_nxt_c = '0;
    end else if (err_vld && !ovf_c) begin
      integ_nxt_c = sum_c;
    end
  end

  always_comb begin
    p_prod_c = PW'(err_q) * PW'(P_COEFF);
    d_prod_c = TW'(diff_sat) * TW'(D_COEFF);
  end

  // Stage 1: sample capture, history shift and integrator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= '0;
      diff_sat <= '0;
      s1_vld   <= 1'b0;
      integ    <= '0;
      for (int unsigned k = 0; k < D_DEPTH; k++) begin
        queue[k] <= '0;
      end
    end else begin
      s1_vld <= err_vld;
      integ  <= integ_nxt_c;
      if (err_vld) begin
        err_q    <= err_sat;
        diff_sat <= diff_sat_c;
        queue[0] <= err_sat;
        for (int unsigned k = 1; k < D_DEPTH; k++) begin
          queue[k] <= queue[k-1];
        end
      end
    end
  end

  // Stage 2: registered terms, held between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P_term    <= '0;
      I_term    <= '0;
      D_term    <= '0;
      terms_vld <= 1'b0;
    end else begin
      terms_vld <= s1_vld;
      if (s1_vld) begin
        P_term <= p_prod_c;
        I_term <= integ[IW-1:6];
        D_term <= d_prod_c;
      end
    end
  end

endmodule

// File: tb/tb_pid_terms.sv
// Self-checking bench for pid_terms: directed table, hand sequences and random traffic against a scoreboard model.
module tb_pid_terms;

  localparam int unsigned D_DEPTH = 2;
  localparam int          P_GAIN  = 8;
  localparam int          D_GAIN  = 7;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [9:0]  err_sat = '0;
  logic               err_vld = 1'b0;
  logic               moving = 1'b0;
  logic signed [15:0] P_term;
  logic signed [11:0] I_term;
  logic signed [12:0] D_term;
  logic               terms_vld;

  pid_terms #(.P_COEFF(6'sd8), .D_COEFF(6'sd7), .D_DEPTH(D_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .err_sat(err_sat), .err_vld(err_vld), .moving(moving),
    .P_term(P_term), .I_term(I_term), .D_term(D_term), .terms_vld(terms_vld)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int i; int d; int due; } exp_t;
  typedef struct { int err; int p; int i; int d; } vec_t;

  exp_t sbq[$];
  int   hist[$];
  int   integ, cnt, checks, errors;
  int   lp, li, ld;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  function automatic void model_clear();
    sbq.delete();
    hist.delete();
    for (int k = 0; k < int'(D_DEPTH); k++) hist.push_back(0);
    integ = 0; lp = 0; li = 0; ld = 0;
  endfunction

  // Reference: plain integer arithmetic on the sample history and a range-limited accumulator.
  function automatic void model(input bit vld, input int e, input bit mov,
                                input bit ut, input int tp, input int ti, input int td);
    exp_t x;
    int   diff, sum;
    diff = 0;
    if (vld) begin
      diff = e - hist[D_DEPTH-1];
      if (diff > 63) diff = 63;
      else if (diff < -64) diff = -64;
      hist.push_front(e);
      void'(hist.pop_back());
    end
    if (!mov) integ = 0;
    else if (vld) begin
      sum = integ + e;
      if (sum <= 131071 && sum >= -131072) integ = sum;
    end
    if (vld) begin
      x.p   = ut ? tp : e * P_GAIN;
      x.i   = ut ? ti : (integ >>> 6);
      x.d   = ut ? td : diff * D_GAIN;
      x.due = cnt + 2;
      sbq.push_back(x);
    end
  endfunction

  // One clock: drive inputs, advance the model, then check outputs 1 time unit after the edge.
  task automatic cyc(input bit vld, input int e, input bit mov,
                     input bit ut = 1'b0, input int tp = 0, input int ti = 0, input int td = 0);
    err_sat = 10'(e);
    err_vld = vld;
    moving  = mov;
    model(vld, e, mov, ut, tp, ti, td);
    @(posedge clk);
    #1;
    cnt++;
    if (sbq.size() > 0 && sbq[0].due == cnt) begin
      exp_t x;
      x = sbq.pop_front();
      chk("terms_vld_pulse", int'(terms_vld), 1);
      chk("P_term", int'(P_term), x.p);
      chk("I_term", int'(I_term), x.i);
      chk("D_term", int'(D_term), x.d);
      lp = x.p; li = x.i; ld = x.d;
    end else begin
      chk("terms_vld_idle", int'(terms_vld), 0);
      chk("P_hold", int'(P_term), lp);
      chk("I_hold", int'(I_term), li);
      chk("D_hold", int'(D_term), ld);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vld"}, int'(terms_vld), 0);
    chk({nm, "_P"}, int'(P_term), 0);
    chk({nm, "_I"}, int'(I_term), 0);
    chk({nm, "_D"}, int'(D_term), 0);
  endtask

  // Reset held over several edges with random traffic; nothing may come out.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      err_sat = 10'($urandom);
      err_vld = 1'($urandom);
      moving  = 1'($urandom);
      @(posedge clk);
      #1;
      cnt++;
      chk_zero("reset");
    end
    err_vld = 1'b0;
    moving  = 1'b0;
    rst_n   = 1'b1;
    model_clear();
  endtask

  vec_t tbl[8];

  initial begin
    checks = 0; errors = 0; cnt = 0;
    model_clear();

    // Directed chain with moving low: integrator stays 0, history feeds D.
    tbl[0] = '{err: 100,  p: 800,   i: 0, d: 441};
    tbl[1] = '{err: 0,    p: 0,     i: 0, d: 0};
    tbl[2] = '{err: 0,    p: 0,     i: 0, d: -448};
    tbl[3] = '{err: 10,   p: 80,    i: 0, d: 70};
    tbl[4] = '{err: 30,   p: 240,   i: 0, d: 210};
    tbl[5] = '{err: -300, p: -2400, i: 0, d: -448};
    tbl[6] = '{err: 511,  p: 4088,  i: 0, d: 441};
    tbl[7] = '{err: -512, p: -4096, i: 0, d: -448};

    do_reset();
    for (int r = 0; r < 8; r++) begin
      cyc(1'b1, tbl[r].err, 1'b0, 1'b1, tbl[r].p, tbl[r].i, tbl[r].d);
      cyc(1'b0, 0, 1'b0);
      cyc(1'b0, 0, 1'b0);
    end

    // Integrator positive saturation then hold.
    do_reset();
    for (int n = 0; n < 257; n++) cyc(1'b1, 511, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    chk("I_sat_pos", int'(I_term), 2044);

    // Clear, then negative saturation.
    cyc(1'b0, 0, 1'b0);
    for (int n = 0; n < 257; n++) cyc(1'b1, -512, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    chk("I_sat_neg", int'(I_term), -2048);

    // moving dropped for one idle cycle clears the integrator but not the history.
    for (int n = 0; n < 3; n++) cyc(1'b1, 200, 1'b1);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b1, 300, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    chk("I_after_clear", int'(I_term), 4);
    chk("D_after_clear", int'(D_term), 441);

    // Five back-to-back strobes.
    for (int n = 0; n < 5; n++) cyc(1'b1, $urandom_range(1023) - 512, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(9) < 7, $urandom_range(1023) - 512, $urandom_range(19) != 0);
    end
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);

    // Async reset in the middle of a back-to-back burst.
    for (int n = 0; n < 3; n++) cyc(1'b1, $urandom_range(1023) - 512, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int c = 0; c < 4; c++) begin
      err_vld = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
      chk_zero("rst_hold");
    end
    err_vld = 1'b0;
    rst_n   = 1'b1;
    model_clear();
    for (int c = 0; c < 4; c++) cyc(1'b0, 0, 1'b1);

    if (sbq.size() != 0) begin
      chk("scoreboard_drain", sbq.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
